// File: rtl/adder_arbiter_pkg.sv
// Shared types, widths and the wrapping round-robin search used by adder_arbiter.
package adder_arbiter_pkg;
  localparam int DATA_W  = 32;
  localparam int SUM_W   = 33;
  localparam int MAX_REQ = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Returns {found, index} of the first set bit at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_search(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0] ptr,
                                           input int n);
    logic [4:0] res;
    int         j;
    res = 5'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!res[4] && req[j]) res = {1'b1, 4'(j)};
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index, search starts at ptr.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [4:0] found_idx;

  assign found_idx = rr_search(MAX_REQ'(req), 4'(ptr), NUM_REQ);
  assign idx       = ID_W'(found_idx[3:0]);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = found_idx[4] & (idx == ID_W'(gi));
  end
endmodule

// File: rtl/adder_arbiter.sv
// One 32-bit adder shared by NUM_REQ requesters, round-robin granted, one-entry result register.
// Define ADDER_ARBITER_SAT_EN to saturate the sum to 32'hFFFFFFFF instead of exposing the carry.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SUM_W-1:0]          res_sum,
  output logic [ID_W-1:0]           res_id
);
  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [SUM_W-1:0]  sum_reg, sum_raw, sum_next;
  logic [ID_W-1:0]   id_reg;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] in1_arr [NUM_REQ];
  logic [DATA_W-1:0] in2_arr [NUM_REQ];
  logic              can_accept, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_reg),
    .grant(grant),
    .idx  (grant_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign in1_arr[gi] = req_in1[DATA_W*gi +: DATA_W];
    assign in2_arr[gi] = req_in2[DATA_W*gi +: DATA_W];
  end

  // rst_n gates ready so nothing is handed over while the block is held in reset.
  assign can_accept = (state_reg == EMPTY) | res_ready;
  assign req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
  assign accept     = |(req_valid & req_ready);

  assign op_a    = in1_arr[grant_idx];
  assign op_b    = in2_arr[grant_idx];
  assign sum_raw = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_ARBITER_SAT_EN
  assign sum_next = sum_raw[DATA_W] ? {1'b0, {DATA_W{1'b1}}} : sum_raw;
`else
  assign sum_next = sum_raw;
`endif

  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (res_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      rr_ptr_reg <= '0;
      sum_reg    <= '0;
      id_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rr_ptr_reg <= rr_ptr_next;
        sum_reg    <= sum_next;
        id_reg     <= grant_idx;
      end
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_sum   = sum_reg;
  assign res_id    = id_reg;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed scoreboard bench for adder_arbiter: stimulus pushes expected results, a monitor pops them.
module tb_adder_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [32:0] sum;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] a, b;
  logic              res_valid;
  logic              res_ready;
  logic [32:0]       res_sum;
  logic [1:0]        res_id;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  adder_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_in1  (a),
    .req_in2  (b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_id   (res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [32:0] sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed result handshake is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got id=%0d sum=0x%0h, none expected", res_id, res_sum);
        end else begin
          e = exp_q.pop_front();
          check("result_id", 64'(res_id), 64'(e.id));
          check("result_sum", 64'(res_sum), 64'(e.sum));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rr_ready_tbl [6];
    logic [32:0]  rr_sum_tbl   [6];
    logic [32:0]  carry_exp1, carry_exp2;
    rr_ready_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_sum_tbl   = '{33'd1, 33'd102, 33'd203, 33'd304, 33'd1, 33'd102};
`ifdef ADDER_ARBITER_SAT_EN
    carry_exp1 = 33'h0FFFFFFFF;
    carry_exp2 = 33'h0FFFFFFFF;
`else
    carry_exp1 = 33'h1FFFFFFFE;
    carry_exp2 = 33'h100000000;
`endif

    // Reset with every requester valid: ready must stay low.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a[i] = 32'(i * 100 + 1);
      b[i] = 32'(i);
    end
    step();
    step();
    @(negedge clk);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res_sum", 64'(res_sum), 64'd0);
    check("reset_res_id", 64'(res_id), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    step();
    rst_n = 1'b1;

    // Round-robin, all valid, one result per cycle.
    for (int k = 0; k < 6; k++) begin
      push(2'(k % 4), rr_sum_tbl[k]);
      @(negedge clk);
      check("rr_req_ready", 64'(req_ready), 64'(rr_ready_tbl[k]));
      if (k > 0) check("rr_res_valid", 64'(res_valid), 64'd1);
      step();
    end

    // Single requester 2: 5 + 7.
    req_valid = 4'b0100;
    a[2] = 32'd5;
    b[2] = 32'd7;
    push(2'd2, 33'd12);
    @(negedge clk);
    check("single_req_ready", 64'(req_ready), 64'b0100);
    step();

    // Wrap and skip: pointer sits at 3, requesters 0 and 1 valid.
    req_valid = 4'b0011;
    a[0] = 32'd10; b[0] = 32'd20;
    a[1] = 32'd30; b[1] = 32'd40;
    push(2'd0, 33'd30);
    push(2'd1, 33'd70);
    @(negedge clk);
    check("wrap_req_ready0", 64'(req_ready), 64'b0001);
    step();
    req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_req_ready1", 64'(req_ready), 64'b0010);
    step();

    // Carry-out cases.
    req_valid = 4'b0001;
    a[0] = 32'hFFFFFFFF; b[0] = 32'hFFFFFFFF;
    push(2'd0, carry_exp1);
    step();
    req_valid = 4'b0010;
    a[1] = 32'h80000000; b[1] = 32'h80000000;
    push(2'd1, carry_exp2);
    step();
    req_valid = 4'b0000;
    step();

    // Backpressure: result held, no accept, then drain + accept together.
    req_valid = 4'b0100;
    a[2] = 32'd1000; b[2] = 32'd1;
    push(2'd2, 33'd1001);
    step();
    res_ready = 1'b0;
    a[2] = 32'd2000; b[2] = 32'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_sum", 64'(res_sum), 64'd1001);
      check("bp_res_id", 64'(res_id), 64'd2);
      step();
    end
    res_ready = 1'b1;
    push(2'd2, 33'd2002);
    @(negedge clk);
    check("bp_release_req_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = 4'b0000;
    step();

    // Reset while FULL discards the held result and rewinds the pointer.
    req_valid = 4'b0001;
    res_ready = 1'b0;
    a[0] = 32'd7; b[0] = 32'd8;
    step();
    @(negedge clk);
    check("pre_reset_full", 64'(res_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_res_valid", 64'(res_valid), 64'd0);
    check("midreset_res_sum", 64'(res_sum), 64'd0);
    check("midreset_res_id", 64'(res_id), 64'd0);
    check("midreset_req_ready", 64'(req_ready), 64'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1001;
    res_ready = 1'b1;
    push(2'd0, 33'd15);
    @(negedge clk);
    check("post_reset_grant", 64'(req_ready), 64'b0001);
    step();
    req_valid = 4'b0000;

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
